nios_security_led_seq: RTL and testbench

NIOS_SECURITY_LED_SEQ -- requirements
Module: nios_security_led_seq

---
 rtl/nios_security_led_seq.sv | 175 +++++++++++++++++
 tb/tb_nios_security_led_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_security_led_seq.sv
// Avalon-MM LED sequencer: plays up to four PATTERN words on out_port, each held DWELL+1 cycles.
// Optional irq output and CTRL.IE bit are enabled by defining NIOS_SECURITY_LED_SEQ_IRQ_EN.
module nios_security_led_seq #(
  parameter int DWELL_W = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] out_port
`ifdef NIOS_SECURITY_LED_SEQ_IRQ_EN
  ,
  output logic        irq
`endif
);

  typedef enum logic {
    S_IDLE,
    S_PLAY
  } state_e;

  state_e               state_q, state_d;
  logic                 run_q, run_d;
  logic                 oneshot_q, oneshot_d;
  logic [1:0]           last_q, last_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 done_q, done_d;
  logic [31:0]          direct_q, direct_d;
  logic [31:0]          pattern_q [4];
  logic [31:0]          pattern_d [4];
  logic [1:0]           idx_q, idx_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [31:0]          out_q, out_d;
  logic                 ie_bit;
  logic                 wr, wr_ctrl;

`ifdef NIOS_SECURITY_LED_SEQ_IRQ_EN
  logic ie_q, ie_d;
  logic irq_q, irq_d;
  assign ie_bit = ie_q;
  assign irq    = irq_q;
`else
  assign ie_bit = 1'b0;
`endif

  assign wr       = chipselect & ~write_n;
  assign wr_ctrl  = wr && (address == 3'd0);
  assign out_port = out_q;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    oneshot_d = oneshot_q;
    last_d    = last_q;
    dwell_d   = dwell_q;
    done_d    = done_q;
    direct_d  = direct_q;
    pattern_d = pattern_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
`ifdef NIOS_SECURITY_LED_SEQ_IRQ_EN
    ie_d      = ie_q;
    irq_d     = done_q & ie_q;
`endif

    if (wr) begin
      case (address)
        3'd0: begin
          run_d     = writedata[0];
          oneshot_d = writedata[1];
          last_d    = writedata[3:2];
`ifdef NIOS_SECURITY_LED_SEQ_IRQ_EN
          ie_d      = writedata[4];
`endif
        end
        3'd1:    dwell_d = writedata[DWELL_W-1:0];
        3'd2:    if (writedata[8]) done_d = 1'b0;
        3'd3:    direct_d = writedata;
        default: pattern_d[address[1:0]] = writedata;
      endcase
    end

    // Step loads read the registered PATTERN/DWELL, so writes during a step wait for the next load.
    case (state_q)
      S_IDLE: begin
        out_d = direct_d;
        if (wr_ctrl && writedata[0]) begin
          state_d = S_PLAY;
          idx_d   = 2'd0;
          cnt_d   = dwell_q;
          out_d   = pattern_q[0];
        end
      end
      S_PLAY: begin
        if (wr_ctrl && !writedata[0]) begin
          state_d = S_IDLE;
          out_d   = direct_d;
        end else if (cnt_q == '0) begin
          cnt_d = dwell_q;
          if (idx_q < last_q) begin
            idx_d = idx_q + 2'd1;
            out_d = pattern_q[idx_q + 2'd1];
          end else if (!oneshot_q) begin
            idx_d = 2'd0;
            out_d = pattern_q[0];
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            out_d   = direct_d;
            // A coincident CPU CTRL write keeps its RUN value.
            if (!wr_ctrl) run_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    readdata = '0;
    case (address)
      3'd0:    readdata = {27'd0, ie_bit, last_q, oneshot_q, run_q};
      3'd1:    readdata = 32'(dwell_q);
      3'd2:    readdata = {23'd0, done_q, 2'd0, idx_q, 3'd0, (state_q == S_PLAY)};
      3'd3:    readdata = direct_q;
      default: readdata = pattern_q[address[1:0]];
    endcase
  end

  // NOTE: the PATTERN array is cleared by reset like any other register; readback must be 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      run_q     <= 1'b0;
      oneshot_q <= 1'b0;
      last_q    <= 2'd0;
      dwell_q   <= '0;
      done_q    <= 1'b0;
      direct_q  <= '0;
      for (int i = 0; i < 4; i++) pattern_q[i] <= '0;
      idx_q     <= 2'd0;
      cnt_q     <= '0;
      out_q     <= '0;
`ifdef NIOS_SECURITY_LED_SEQ_IRQ_EN
      ie_q      <= 1'b0;
      irq_q     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q   <= state_d;
      run_q     <= run_d;
      oneshot_q <= oneshot_d;
      last_q    <= last_d;
      dwell_q   <= dwell_d;
      done_q    <= done_d;
      direct_q  <= direct_d;
      pattern_q <= pattern_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
`ifdef NIOS_SECURITY_LED_SEQ_IRQ_EN
      ie_q      <= ie_d;
      irq_q     <= irq_d;
`endif
    end
  end

endmodule

// File: tb/tb_nios_security_led_seq.sv
// Self-checking bench for nios_security_led_seq: directed scenarios plus random bus traffic
// checked against a step-level behavioural model of the sequencer.
module tb_nios_security_led_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] out_port;
`ifdef NIOS_SECURITY_LED_SEQ_IRQ_EN
  logic        irq;
`endif

  nios_security_led_seq #(.DWELL_W(24)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
`ifdef NIOS_SECURITY_LED_SEQ_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural model: a sequence is "playing step m_step with m_left extra cycles to go".
  bit          m_play, m_run, m_os, m_ie, m_done, m_irq;
  logic [1:0]  m_last, m_step;
  logic [23:0] m_dwell;
  logic [31:0] m_direct, m_out;
  logic [31:0] m_pat [4];
  int          m_left;

  task automatic m_reset();
    m_play = 0; m_run = 0; m_os = 0; m_ie = 0; m_done = 0; m_irq = 0;
    m_last = 0; m_step = 0; m_dwell = 0; m_direct = 0; m_out = 0; m_left = 0;
    for (int i = 0; i < 4; i++) m_pat[i] = 0;
  endtask

  function automatic logic [31:0] m_read(input int a);
    case (a)
      0:       return (32'(m_ie) << 4) | (32'(m_last) << 2) | (32'(m_os) << 1) | 32'(m_run);
      1:       return 32'(m_dwell);
      2:       return (32'(m_done) << 8) | (32'(m_step) << 4) | 32'(m_play);
      3:       return m_direct;
      default: return m_pat[a-4];
    endcase
  endfunction

  task automatic m_clock(input bit w, input int a, input logic [31:0] d);
    bit          ctrl = w && (a == 0);
    bit          np = m_play, load = 0, finish = 0;
    logic [1:0]  nstep = m_step;
    int          nleft = m_left;
    logic [31:0] nout = m_out;
    logic [31:0] old_pat [4];
    bit          nirq = m_done & m_ie;
    old_pat = m_pat;
    if (!m_play) begin
      if (ctrl && d[0]) begin np = 1; nstep = 0; nleft = int'(m_dwell); load = 1; end
    end else if (ctrl && !d[0]) begin
      np = 0;
    end else if (m_left > 0) begin
      nleft--;
    end else begin
      nleft = int'(m_dwell);
      if (m_step < m_last) begin nstep = m_step + 2'd1; load = 1; end
      else if (!m_os)      begin nstep = 0; load = 1; end
      else                 begin np = 0; finish = 1; end
    end
    if (w) begin
      case (a)
        0: begin
          m_run = d[0]; m_os = d[1]; m_last = d[3:2];
`ifdef NIOS_SECURITY_LED_SEQ_IRQ_EN
          m_ie = d[4];
`endif
        end
        1: m_dwell = d[23:0];
        2: if (d[8]) m_done = 0;
        3: m_direct = d;
        default: m_pat[a-4] = d;
      endcase
    end
    if (finish) begin
      m_done = 1;
      if (!ctrl) m_run = 0;
    end
    if (!np)       nout = m_direct;
    else if (load) nout = old_pat[nstep];
    m_play = np; m_step = nstep; m_left = nleft; m_out = nout; m_irq = nirq;
  endtask

  // One bus cycle: starts and ends 1 time unit after a rising edge.
  task automatic cyc(input bit w, input int a, input logic [31:0] d);
    chipselect = w;
    write_n    = !w;
    address    = 3'(a);
    writedata  = d;
    #1;
    if (!w) check("read", readdata, m_read(a));
    m_clock(w, a, d);
    @(posedge clk);
    #1;
    chipselect = 0;
    write_n    = 1;
    check("out", out_port, m_out);
`ifdef NIOS_SECURITY_LED_SEQ_IRQ_EN
    check("irq", 32'(irq), 32'(m_irq));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 2, 0);
  endtask

  task automatic load_pattern();
    cyc(1, 4, 1); cyc(1, 5, 2); cyc(1, 6, 4); cyc(1, 7, 8);
    cyc(1, 1, 2);
    cyc(1, 3, 32'hA5);
  endtask

  initial begin
    reset_n = 0; chipselect = 0; write_n = 1; address = 0; writedata = 0;
    m_reset();
    #23;
    check("rst_out", out_port, 0);
    check("rst_ctrl", readdata, 0);
    address = 2; #1;
    check("rst_status", readdata, 0);
    @(posedge clk); #1;
    reset_n = 1;

    // DIRECT write visible after one edge, and read back
    cyc(1, 3, 32'h0000_00A5);
    check("direct_out", out_port, 32'hA5);
    cyc(0, 3, 0);

    // Looping four-step pattern, 3 cycles per step
    load_pattern();
    cyc(1, 0, 32'h0D);
    check("seq", out_port, 1);
    for (int k = 1; k < 24; k++) begin
      cyc(0, 2, 0);
      check("seq", out_port, 32'd1 << ((k / 3) % 4));
      check("busy", readdata & 32'h1, 1);
    end
    cyc(1, 0, 0);

    // One-shot: returns to DIRECT after 12 cycles, DONE set, RUN cleared
    cyc(1, 0, 32'h0F);
    idle(12);
    check("os_out", out_port, 32'hA5);
    address = 0; #1;
    check("os_ctrl", readdata, 32'h0E);
    address = 2; #1;
    check("os_status", readdata, 32'h130);
    cyc(1, 2, 32'h100);
    address = 2; #1;
    check("done_clr", readdata, 32'h030);

    // Abort mid-sequence
    cyc(1, 0, 32'h0D);
    idle(4);
    cyc(1, 0, 0);
    check("stop_out", out_port, 32'hA5);
    address = 2; #1;
    check("stop_status", readdata & 32'h101, 0);

    // DWELL=0, LAST=1 alternation, then LAST=0 lock-on
    cyc(1, 1, 0);
    cyc(1, 0, 32'h05);
    for (int k = 0; k < 6; k++) begin
      check("alt", out_port, (k % 2 == 0) ? 32'd1 : 32'd2);
      cyc(0, 2, 0);
    end
    cyc(1, 0, 32'h01);
    cyc(0, 2, 0);
    for (int k = 0; k < 4; k++) begin
      check("lock", out_port, 1);
      cyc(0, 2, 0);
    end
    cyc(1, 0, 0);

    // Reset mid-PLAY
    cyc(1, 1, 2);
    cyc(1, 0, 32'h0D);
    idle(4);
    reset_n = 0;
    #1;
    m_reset();
    check("mid_rst_out", out_port, 0);
    address = 2; #1;
    check("mid_rst_status", readdata, 0);
    reset_n = 1;
    idle(2);
    check("post_rst_out", out_port, 0);

`ifdef NIOS_SECURITY_LED_SEQ_IRQ_EN
    load_pattern();
    cyc(1, 0, 32'h1F);
    idle(12);
    check("irq_lag", 32'(irq), 0);
    cyc(0, 2, 0);
    check("irq_rise", 32'(irq), 1);
    cyc(1, 2, 32'h100);
    cyc(1, 0, 0);
`endif

    // Random traffic against the model
    for (int n = 0; n < 500; n++) begin
      bit          w = ($urandom_range(0, 2) == 0);
      int          a = int'($urandom_range(0, 7));
      logic [31:0] d = $urandom;
      if (a == 1) d = $urandom_range(0, 3);
      if (a == 0) d = (d & 32'h1E) | 32'($urandom_range(0, 3) != 0);
      cyc(w, a, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
